// File: rtl/wbf_rd_arb.sv
// Round-robin arbiter sharing the Weight Buffer read port among NUM_PORT requesters,
// with an in-order tag FIFO routing returned data. Define WBF_ARB_STAT_EN for per-port grant counters.
module wbf_rd_arb #(
  parameter int NUM_PORT       = 4,
  parameter int WEI_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_OUTSTD     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               TOPARB_CfgVld,
  output logic                               ARBTOP_CfgRdy,
  output logic                               ARBTOP_Busy,
  output logic                               ARBTOP_Err,
  input  logic [NUM_PORT-1:0]                PORARB_AdrVld,
  input  logic [NUM_PORT*WEI_ADDR_WIDTH-1:0] PORARB_Adr,
  output logic [NUM_PORT-1:0]                ARBPOR_AdrRdy,
  output logic [NUM_PORT-1:0]                ARBPOR_DatVld,
  output logic [NUM_PORT*DATA_WIDTH-1:0]     ARBPOR_Dat,
  input  logic [NUM_PORT-1:0]                PORARB_DatRdy,
  output logic                               ARBWBF_AdrVld,
  output logic [WEI_ADDR_WIDTH-1:0]          ARBWBF_Adr,
  input  logic                               WBFARB_AdrRdy,
  input  logic                               WBFARB_DatVld,
  input  logic [DATA_WIDTH-1:0]              WBFARB_Dat,
  output logic                               ARBWBF_DatRdy
`ifdef WBF_ARB_STAT_EN
  ,
  output logic [NUM_PORT*16-1:0]             ARBTOP_GntCnt
`endif
);

  localparam int PW = $clog2(NUM_PORT);
  localparam int AW = $clog2(MAX_OUTSTD);
  localparam int CW = AW + 1;
  localparam logic [PW:0]   NP_W   = NUM_PORT[PW:0];
  localparam logic [PW-1:0] LAST_P = PW'(NUM_PORT - 1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTD);

  typedef enum logic [1:0] {S_IDLE, S_WORK, S_DRAIN} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   tags [MAX_OUTSTD];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   sel, head;
  logic [PW:0]     scan;
  logic            found, push, pop, not_empty;

  // Round-robin scan starting at rr_ptr; first requester found wins.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    scan  = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(i);
      if (scan >= NP_W) scan = scan - NP_W;
      if (!found && PORARB_AdrVld[scan[PW-1:0]]) begin
        found = 1'b1;
        sel   = scan[PW-1:0];
      end
    end
  end

  assign ARBWBF_AdrVld = (state == S_WORK) && (cnt != MAX_C) && found;
  assign ARBWBF_Adr    = PORARB_Adr[sel*WEI_ADDR_WIDTH +: WEI_ADDR_WIDTH];
  assign push          = ARBWBF_AdrVld & WBFARB_AdrRdy;

  assign head          = tags[rd_ptr];
  assign not_empty     = (cnt != '0);
  assign ARBWBF_DatRdy = not_empty & PORARB_DatRdy[head];
  assign pop           = WBFARB_DatVld & ARBWBF_DatRdy;
  assign ARBPOR_Dat    = {NUM_PORT{WBFARB_Dat}};

  always_comb begin
    ARBPOR_AdrRdy = '0;
    ARBPOR_DatVld = '0;
    if (push) ARBPOR_AdrRdy[sel] = 1'b1;
    if (WBFARB_DatVld && not_empty) ARBPOR_DatVld[head] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ARBTOP_CfgRdy <= 1'b1;
      ARBTOP_Busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (TOPARB_CfgVld) begin
          state         <= S_WORK;
          ARBTOP_CfgRdy <= 1'b0;
          ARBTOP_Busy   <= 1'b1;
        end
        S_WORK: if (TOPARB_CfgVld) state <= S_DRAIN;
        S_DRAIN: if (!not_empty && !pop) begin
          state         <= S_IDLE;
          ARBTOP_CfgRdy <= 1'b1;
          ARBTOP_Busy   <= 1'b0;
        end
        default: begin
          state         <= S_IDLE;
          ARBTOP_CfgRdy <= 1'b1;
          ARBTOP_Busy   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      ARBTOP_Err <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (sel == LAST_P) ? '0 : sel + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (WBFARB_DatVld && !not_empty) ARBTOP_Err <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; cnt and the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= sel;
  end

`ifdef WBF_ARB_STAT_EN
  logic [15:0] gnt_cnt [NUM_PORT];
  logic        start;

  assign start = (state == S_IDLE) && TOPARB_CfgVld;

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORT; p++) begin
      if (rst || start)
        gnt_cnt[p] <= '0;
      else if (push && (sel == PW'(p)) && (gnt_cnt[p] != 16'hFFFF))
        gnt_cnt[p] <= gnt_cnt[p] + 16'd1;
    end
  end

  always_comb begin
    ARBTOP_GntCnt = '0;
    for (int p = 0; p < NUM_PORT; p++) ARBTOP_GntCnt[p*16 +: 16] = gnt_cnt[p];
  end
`endif

endmodule
